// File: rtl/mod_n_mon_pkg.sv
// Shared types and helpers for the mod-N count monitor: FSM states, event
// type codes and the expected-next-value function.
package mod_n_mon_pkg;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCKED   = 2'd1,
    FAULT    = 2'd2
  } mon_state_e;

  localparam logic [1:0] WRAP     = 2'b01;
  localparam logic [1:0] MISMATCH = 2'b10;
  localparam logic [1:0] RANGE    = 2'b11;

  // Callers zero-extend into this width and truncate the result back.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] next_expected(input logic [MAX_W-1:0] prev,
                                                     input logic [MAX_W-1:0] last);
    return (prev == last) ? '0 : prev + 1'b1;
  endfunction

endpackage

// File: rtl/mon_evt_fifo.sv
// Two-entry first-word-fall-through FIFO with registered outputs; reports
// pushes that could not be accepted so the owner can flag an overflow.
module mon_evt_fifo #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear_i,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  output logic          full_o,
  output logic          drop_o,
  output logic          valid_o,
  input  logic          ready_i,
  output logic [DW-1:0] data_o
);

  logic [DW-1:0] head_q, tail_q;
  logic [1:0]    cnt_q;
  logic          pop, accept;

  assign pop     = (cnt_q != 2'd0) && ready_i;
  assign full_o  = (cnt_q == 2'd2);
  assign accept  = push_i && (!full_o || pop);
  assign drop_o  = push_i && !accept;
  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = head_q;

  // The head register is the output, so a waiting record never changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else if (clear_i) begin
      cnt_q <= 2'd0;
    end else begin
      case ({pop, accept})
        2'b11: begin
          if (cnt_q == 2'd1) begin
            head_q <= data_i;
          end else begin
            head_q <= tail_q;
            tail_q <= data_i;
          end
        end
        2'b10: begin
          head_q <= tail_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        2'b01: begin
          if (cnt_q == 2'd0) head_q <= data_i;
          else               tail_q <= data_i;
          cnt_q <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mod_n_count_monitor.sv
// Observer that checks an upstream mod-N counter, counts wraps and anomalies
// and queues event records. Define MOD_N_MON_TIMESTAMP_EN to timestamp records.
module mod_n_count_monitor
  import mod_n_mon_pkg::*;
#(
  parameter int N       = 256,
  parameter int WIDTH   = 32,
  parameter int CNT_W   = 16,
  parameter int ERR_MAX = 4
`ifdef MOD_N_MON_TIMESTAMP_EN
  , parameter int TS_W  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [WIDTH-1:0]      count_in,
  input  logic                  count_load,
  input  logic                  clear,
  output logic                  wrap_pulse,
  output logic                  err_pulse,
  output logic [CNT_W-1:0]      wrap_count,
  output logic [CNT_W-1:0]      err_count,
  output logic                  locked,
  output logic                  fault,
  output logic                  ovf_sticky,
  output logic                  evt_valid,
  input  logic                  evt_ready,
`ifdef MOD_N_MON_TIMESTAMP_EN
  output logic [TS_W+2+WIDTH-1:0] evt_data
`else
  output logic [2+WIDTH-1:0]    evt_data
`endif
);

`ifdef MOD_N_MON_TIMESTAMP_EN
  localparam int EVT_W = TS_W + 2 + WIDTH;
`else
  localparam int EVT_W = 2 + WIDTH;
`endif
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(N - 1);
  localparam logic [MAX_W-1:0] N_EXT   = MAX_W'(N);
  localparam logic [3:0]       ERR_LIM = 4'(ERR_MAX);

  mon_state_e       state_q, state_d;
  logic [WIDTH-1:0] prev_q;
  logic [3:0]       consec_q, consec_d;
  logic             wrap_pulse_q, err_pulse_q, ovf_q;
  logic [CNT_W-1:0] wrap_cnt_q, err_cnt_q;
  logic [WIDTH-1:0] exp_val;
  logic             checking, is_range, is_mismatch, is_wrap, anomaly;
  logic [1:0]       evt_type;
  logic             push, fifo_full, fifo_drop;
  logic [EVT_W-1:0] push_data;

  assign exp_val = WIDTH'(next_expected(MAX_W'(prev_q), MAX_W'(LAST)));

  always_comb begin
    checking    = (state_q == LOCKED) && !count_load && !clear;
    is_range    = checking && (MAX_W'(count_in) >= N_EXT);
    is_mismatch = checking && !is_range && (count_in != exp_val);
    anomaly     = is_range || is_mismatch;
    is_wrap     = checking && !anomaly && (prev_q == LAST) && (count_in == '0);
    evt_type    = is_range ? RANGE : (is_mismatch ? MISMATCH : WRAP);
    push        = is_wrap || anomaly;

    state_d  = state_q;
    consec_d = consec_q;
    if (clear) begin
      state_d  = UNLOCKED;
      consec_d = 4'd0;
    end else begin
      case (state_q)
        UNLOCKED: begin
          consec_d = 4'd0;
          state_d  = count_load ? UNLOCKED : LOCKED;
        end
        LOCKED: begin
          if (count_load) begin
            state_d  = UNLOCKED;
            consec_d = 4'd0;
          end else if (anomaly) begin
            consec_d = consec_q + 4'd1;
            if (consec_d >= ERR_LIM) state_d = FAULT;
          end else begin
            consec_d = 4'd0;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= UNLOCKED;
      consec_q <= 4'd0;
    end else begin
      state_q  <= state_d;
      consec_q <= consec_d;
    end
  end

  // Statistics only move on checked samples, which freezes them in FAULT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q       <= '0;
      wrap_pulse_q <= 1'b0;
      err_pulse_q  <= 1'b0;
      wrap_cnt_q   <= '0;
      err_cnt_q    <= '0;
      ovf_q        <= 1'b0;
    end else begin
      prev_q       <= count_in;
      wrap_pulse_q <= is_wrap;
      err_pulse_q  <= anomaly;
      if (clear) begin
        wrap_cnt_q <= '0;
        err_cnt_q  <= '0;
        ovf_q      <= 1'b0;
      end else begin
        if (is_wrap && (wrap_cnt_q != '1)) wrap_cnt_q <= wrap_cnt_q + 1'b1;
        if (anomaly && (err_cnt_q != '1))  err_cnt_q  <= err_cnt_q + 1'b1;
        if (fifo_drop)                     ovf_q      <= 1'b1;
      end
    end
  end

`ifdef MOD_N_MON_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     ts_q <= '0;
    else if (clear) ts_q <= '0;
    else            ts_q <= ts_q + 1'b1;
  end

  assign push_data = {ts_q, evt_type, count_in};
`else
  assign push_data = {evt_type, count_in};
`endif

  mon_evt_fifo #(.DW(EVT_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear_i (clear),
    .push_i  (push),
    .data_i  (push_data),
    .full_o  (fifo_full),
    .drop_o  (fifo_drop),
    .valid_o (evt_valid),
    .ready_i (evt_ready),
    .data_o  (evt_data)
  );

  assign wrap_pulse = wrap_pulse_q;
  assign err_pulse  = err_pulse_q;
  assign wrap_count = wrap_cnt_q;
  assign err_count  = err_cnt_q;
  assign locked     = (state_q == LOCKED);
  assign fault      = (state_q == FAULT);
  assign ovf_sticky = ovf_q;

endmodule

// File: tb/tb_mod_n_count_monitor.sv
// Directed bench for mod_n_count_monitor with N=8, WIDTH=4, ERR_MAX=2.
module tb_mod_n_count_monitor;

  localparam int N       = 8;
  localparam int WIDTH   = 4;
  localparam int CNT_W   = 8;
  localparam int ERR_MAX = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] count_in = '0;
  logic             count_load = 1'b0;
  logic             clear = 1'b0;
  logic             wrap_pulse, err_pulse, locked, fault, ovf_sticky, evt_valid;
  logic [CNT_W-1:0] wrap_count, err_count;
  logic             evt_ready = 1'b1;
  logic [2+WIDTH-1:0] evt_data;

  int checks = 0;
  int errors = 0;

  mod_n_count_monitor #(.N(N), .WIDTH(WIDTH), .CNT_W(CNT_W), .ERR_MAX(ERR_MAX)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_in   (count_in),
    .count_load (count_load),
    .clear      (clear),
    .wrap_pulse (wrap_pulse),
    .err_pulse  (err_pulse),
    .wrap_count (wrap_count),
    .err_count  (err_count),
    .locked     (locked),
    .fault      (fault),
    .ovf_sticky (ovf_sticky),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data)
  );

  always #5 clk = ~clk;

  // Present one sample, let the edge take it, and settle 1ns past the edge.
  task automatic drive(input logic [WIDTH-1:0] v, input logic ld);
    count_in   = v;
    count_load = ld;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++; if ({wrap_pulse, err_pulse, locked, fault, ovf_sticky, evt_valid} !== 6'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b expected 000000", {wrap_pulse, err_pulse, locked, fault, ovf_sticky, evt_valid}); end
    checks++; if ({wrap_count, err_count} !== 16'h0) begin errors++; $display("[TB] FAIL reset_counts: got %h expected 0000", {wrap_count, err_count}); end
    rst_n = 1'b1;
  endtask

  task automatic test_lock_wrap();
    drive(4'd0, 1'b0);
    checks++; if (locked !== 1'b1) begin errors++; $display("[TB] FAIL lock_after_first: got %b expected 1", locked); end
    for (int v = 1; v <= 7; v++) drive(4'(v), 1'b0);
    checks++; if (wrap_pulse !== 1'b0 || err_pulse !== 1'b0) begin errors++; $display("[TB] FAIL no_pulse_before_wrap: got %b%b expected 00", wrap_pulse, err_pulse); end
    drive(4'd0, 1'b0);
    checks++; if (wrap_pulse !== 1'b1) begin errors++; $display("[TB] FAIL wrap_pulse: got %b expected 1", wrap_pulse); end
    checks++; if (wrap_count !== 8'd1) begin errors++; $display("[TB] FAIL wrap_count1: got %0d expected 1", wrap_count); end
    checks++; if (evt_valid !== 1'b1 || evt_data !== 6'b01_0000) begin errors++; $display("[TB] FAIL wrap_event: got v=%b d=%b expected v=1 d=010000", evt_valid, evt_data); end
    drive(4'd1, 1'b0);
    checks++; if (wrap_pulse !== 1'b0 || evt_valid !== 1'b0) begin errors++; $display("[TB] FAIL wrap_one_cycle: got p=%b v=%b expected 0 0", wrap_pulse, evt_valid); end
  endtask

  task automatic test_mismatch();
    drive(4'd2, 1'b0);
    drive(4'd3, 1'b0);
    drive(4'd4, 1'b0);
    drive(4'd6, 1'b0);
    checks++; if (err_pulse !== 1'b1 || err_count !== 8'd1) begin errors++; $display("[TB] FAIL mismatch_pulse: got p=%b cnt=%0d expected 1 1", err_pulse, err_count); end
    checks++; if (evt_data !== 6'b10_0110 || evt_valid !== 1'b1) begin errors++; $display("[TB] FAIL mismatch_event: got v=%b d=%b expected v=1 d=100110", evt_valid, evt_data); end
    drive(4'd7, 1'b0);
    checks++; if (err_pulse !== 1'b0 || err_count !== 8'd1 || locked !== 1'b1) begin errors++; $display("[TB] FAIL resync_from_6: got p=%b cnt=%0d lk=%b expected 0 1 1", err_pulse, err_count, locked); end
  endtask

  task automatic test_range_fault();
    drive(4'd0, 1'b0);
    checks++; if (wrap_count !== 8'd2) begin errors++; $display("[TB] FAIL wrap_count2: got %0d expected 2", wrap_count); end
    drive(4'd1, 1'b0);
    drive(4'd2, 1'b0);
    drive(4'd9, 1'b0);
    checks++; if (evt_data !== 6'b11_1001 || err_pulse !== 1'b1 || fault !== 1'b0) begin errors++; $display("[TB] FAIL range_event: got d=%b p=%b f=%b expected 111001 1 0", evt_data, err_pulse, fault); end
    drive(4'd5, 1'b0);
    checks++; if (fault !== 1'b1 || locked !== 1'b0 || err_count !== 8'd3) begin errors++; $display("[TB] FAIL enter_fault: got f=%b lk=%b cnt=%0d expected 1 0 3", fault, locked, err_count); end
    checks++; if (evt_data !== 6'b10_0101) begin errors++; $display("[TB] FAIL second_anomaly_event: got %b expected 100101", evt_data); end
    drive(4'd6, 1'b0);
    drive(4'd7, 1'b0);
    drive(4'd0, 1'b0);
    checks++; if ({wrap_pulse, err_pulse, evt_valid} !== 3'b000 || wrap_count !== 8'd2 || err_count !== 8'd3) begin errors++; $display("[TB] FAIL fault_frozen: got pev=%b w=%0d e=%0d expected 000 2 3", {wrap_pulse, err_pulse, evt_valid}, wrap_count, err_count); end
  endtask

  task automatic test_overflow();
    clear = 1'b1;
    drive(4'd0, 1'b0);
    clear = 1'b0;
    checks++; if (fault !== 1'b0 || wrap_count !== 8'd0 || err_count !== 8'd0) begin errors++; $display("[TB] FAIL clear_basic: got f=%b w=%0d e=%0d expected 0 0 0", fault, wrap_count, err_count); end
    evt_ready = 1'b0;
    for (int w = 0; w < 3; w++) begin
      for (int v = 1; v <= 7; v++) drive(4'(v), 1'b0);
      drive(4'd0, 1'b0);
      if (w == 1) begin
        checks++; if (ovf_sticky !== 1'b0) begin errors++; $display("[TB] FAIL ovf_early: got %b expected 0", ovf_sticky); end
      end
    end
    checks++; if (ovf_sticky !== 1'b1 || wrap_count !== 8'd3) begin errors++; $display("[TB] FAIL overflow: got ovf=%b w=%0d expected 1 3", ovf_sticky, wrap_count); end
    checks++; if (evt_valid !== 1'b1 || evt_data !== 6'b01_0000) begin errors++; $display("[TB] FAIL held_head: got v=%b d=%b expected 1 010000", evt_valid, evt_data); end
    evt_ready = 1'b1;
    drive(4'd1, 1'b0);
    checks++; if (evt_valid !== 1'b1 || evt_data !== 6'b01_0000) begin errors++; $display("[TB] FAIL drain_second: got v=%b d=%b expected 1 010000", evt_valid, evt_data); end
    drive(4'd2, 1'b0);
    checks++; if (evt_valid !== 1'b0 || ovf_sticky !== 1'b1) begin errors++; $display("[TB] FAIL drained: got v=%b ovf=%b expected 0 1", evt_valid, ovf_sticky); end
  endtask

  task automatic test_load();
    drive(4'd5, 1'b1);
    checks++; if (err_pulse !== 1'b0 || locked !== 1'b0) begin errors++; $display("[TB] FAIL load_point: got p=%b lk=%b expected 0 0", err_pulse, locked); end
    drive(4'd6, 1'b0);
    drive(4'd7, 1'b0);
    drive(4'd0, 1'b0);
    checks++; if (wrap_pulse !== 1'b1 || wrap_count !== 8'd4 || err_count !== 8'd0) begin errors++; $display("[TB] FAIL load_wrap: got p=%b w=%0d e=%0d expected 1 4 0", wrap_pulse, wrap_count, err_count); end
    drive(4'd1, 1'b0);
  endtask

  task automatic test_clear_fault();
    evt_ready = 1'b0;
    drive(4'd9, 1'b0);
    drive(4'd3, 1'b0);
    checks++; if (fault !== 1'b1 || evt_valid !== 1'b1 || err_count !== 8'd2) begin errors++; $display("[TB] FAIL pre_clear: got f=%b v=%b e=%0d expected 1 1 2", fault, evt_valid, err_count); end
    clear = 1'b1;
    drive(4'd0, 1'b0);
    clear = 1'b0;
    checks++; if ({fault, locked, evt_valid, ovf_sticky} !== 4'b0000) begin errors++; $display("[TB] FAIL clear_flags: got %b expected 0000", {fault, locked, evt_valid, ovf_sticky}); end
    checks++; if ({wrap_count, err_count} !== 16'h0) begin errors++; $display("[TB] FAIL clear_counts: got %h expected 0000", {wrap_count, err_count}); end
  endtask

  task automatic test_async_reset();
    for (int v = 1; v <= 7; v++) drive(4'(v), 1'b0);
    drive(4'd0, 1'b0);
    checks++; if (wrap_count !== 8'd1 || evt_valid !== 1'b1) begin errors++; $display("[TB] FAIL before_reset: got w=%0d v=%b expected 1 1", wrap_count, evt_valid); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({wrap_pulse, locked, evt_valid, wrap_count} !== 11'h0) begin errors++; $display("[TB] FAIL async_reset: got %h expected 000", {wrap_pulse, locked, evt_valid, wrap_count}); end
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_lock_wrap();
    test_mismatch();
    test_range_fault();
    test_overflow();
    test_load();
    test_clear_fault();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
